// File: rtl/mem_pkg.sv
// Shared definitions for the byte-serial memory master: op encodings, FSM states
// and the access-size decode.
package mem_pkg;

    typedef enum logic [2:0] {
        OP_WORD   = 3'b000,
        OP_BYTE   = 3'b001,
        OP_HALF   = 3'b010,
        OP_BYTE_U = 3'b101,
        OP_HALF_U = 3'b110
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DONE
    } state_e;

    localparam int unsigned BUF_W = 32;

    localparam logic [2:0] SIZE_NONE = 3'd0;
    localparam logic [2:0] SIZE_BYTE = 3'd1;
    localparam logic [2:0] SIZE_HALF = 3'd2;
    localparam logic [2:0] SIZE_WORD = 3'd4;

    // Number of byte beats for an op; SIZE_NONE marks an unknown encoding.
    function automatic logic [2:0] op_size(input logic [2:0] op);
        logic [2:0] n;
        case (op)
            OP_WORD:            n = SIZE_WORD;
            OP_BYTE, OP_BYTE_U: n = SIZE_BYTE;
            OP_HALF, OP_HALF_U: n = SIZE_HALF;
            default:            n = SIZE_NONE;
        endcase
        return n;
    endfunction

    // Unsigned variants only make sense for loads.
    function automatic logic op_legal(input logic we, input logic [2:0] op);
        return (op_size(op) != SIZE_NONE) && !(we && op[2]);
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of an assembled little-endian load buffer to CPU width.
module mem_load_ext
    import mem_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic [BUF_W-1:0]  buffer,
    input  logic [2:0]        op,
    output logic [WORD_W-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_WORD:   result = WORD_W'(buffer);
            OP_BYTE:   result = {{(WORD_W-8){buffer[7]}}, buffer[7:0]};
            OP_HALF:   result = {{(WORD_W-16){buffer[15]}}, buffer[15:0]};
            OP_BYTE_U: result = WORD_W'(buffer[7:0]);
            OP_HALF_U: result = WORD_W'(buffer[15:0]);
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/mem_byte_master.sv
// Converts one CPU load/store into N byte-wide memory beats and returns a single
// extended response.
module mem_byte_master
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [BUF_W-1:0]  buffer_q, buffer_d;
    logic [BUF_W-1:0]  asm_buf;
    logic              we_q, we_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [WORD_W-1:0] ext_result;
    logic              last_byte;

    // Buffer with the current beat's byte already merged, so the final response
    // can be registered on the same edge as the last capture.
    always_comb begin
        asm_buf = buffer_q;
        asm_buf[{idx_q, 3'b000} +: 8] = mem_rdata;
    end

    mem_load_ext #(.WORD_W(WORD_W)) u_load_ext (
        .buffer (asm_buf),
        .op     (op_q),
        .result (ext_result)
    );

    assign last_byte = ({1'b0, idx_q} == (op_size(op_q) - 3'd1));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        buffer_d     = buffer_q;
        we_d         = we_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    op_d     = req_op;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    idx_d    = 2'd0;
                    buffer_d = '0;
                    if (op_legal(req_we, req_op)) begin
                        state_d = ST_XFER;
                    end else begin
                        state_d      = ST_DONE;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end
                end
            end
            ST_XFER: begin
                // A reset arriving mid-transfer must not let this beat's write land.
                mem_en    = !rst;
                mem_we    = we_q && !rst;
                mem_addr  = addr_q + ADDR_W'(idx_q);
                mem_wdata = wdata_q[{idx_q, 3'b000} +: 8];
                buffer_d  = asm_buf;
                idx_d     = idx_q + 2'd1;
                if (last_byte) begin
                    state_d      = ST_DONE;
                    resp_rdata_d = we_q ? '0 : ext_result;
                    resp_err_d   = 1'b0;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            buffer_q     <= '0;
            we_q         <= 1'b0;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            buffer_q     <= buffer_d;
            we_q         <= we_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_DONE);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_byte_master.sv
// Directed bench for mem_byte_master with a 256-byte memory model aliased on
// the low address byte.
module tb_mem_byte_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } acc_t;
    acc_t acc_log[$];

    logic [7:0] mem_arr [256];
    logic       pre_en = 1'b0;
    logic [7:0] pre_addr = 8'h00;
    logic [7:0] pre_data = 8'h00;

    mem_byte_master #(.ADDR_W(32), .WORD_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_arr[mem_addr[7:0]];

    always @(posedge clk) begin
        if (pre_en) mem_arr[pre_addr] <= pre_data;
        else if (mem_en && mem_we) mem_arr[mem_addr[7:0]] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_en) acc_log.push_back('{mem_addr, mem_we, mem_wdata});
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    // Issue one request, then wait (bounded) for resp_valid; lat counts cycles after accept.
    task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output int base);
        @(negedge clk);
        base = acc_log.size();
        req_we = we; req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b exp 0", resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got %h exp 0", resp_rdata); end
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_strobes got en=%b we=%b exp 0/0", mem_en, mem_we); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 8'h0) begin errors++; $display("FAIL reset_mem_bus got addr=%h wdata=%h exp 0/0", mem_addr, mem_wdata); end
        rst = 1'b0;
    endtask

    task automatic test_word_load();
        int lat, base;
        poke(8'h10, 8'h78); poke(8'h11, 8'h56); poke(8'h12, 8'h34); poke(8'h13, 8'h12);
        do_req(1'b0, 3'b000, 32'h10, 32'h0, lat, base);
        checks++; if (lat !== 5) begin errors++; $display("FAIL word_latency got %0d exp 5", lat); end
        checks++; if (resp_rdata !== 32'h12345678) begin errors++; $display("FAIL word_rdata got %h exp 12345678", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL word_err got %b exp 0", resp_err); end
        checks++; if (acc_log.size() - base !== 4) begin errors++; $display("FAIL word_beats got %0d exp 4", acc_log.size() - base); end
        if (acc_log.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (acc_log[base+i].addr !== 32'h10 + 32'(i) || acc_log[base+i].we !== 1'b0) begin
                    errors++;
                    $display("FAIL word_beat%0d got addr=%h we=%b exp addr=%h we=0", i, acc_log[base+i].addr, acc_log[base+i].we, 32'h10 + 32'(i));
                end
            end
        end
        release_resp();
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL word_release got ready=%b valid=%b exp 1/0", req_ready, resp_valid); end
    endtask

    task automatic test_byte_ext();
        int lat, base;
        poke(8'h20, 8'h80);
        do_req(1'b0, 3'b001, 32'h20, 32'h0, lat, base);
        checks++; if (lat !== 2) begin errors++; $display("FAIL byte_latency got %0d exp 2", lat); end
        checks++; if (resp_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_signed got %h exp ffffff80", resp_rdata); end
        release_resp();
        do_req(1'b0, 3'b101, 32'h20, 32'h0, lat, base);
        checks++; if (resp_rdata !== 32'h00000080) begin errors++; $display("FAIL byte_unsigned got %h exp 00000080", resp_rdata); end
        release_resp();
        poke(8'h40, 8'h34); poke(8'h41, 8'h92);
        do_req(1'b0, 3'b010, 32'h40, 32'h0, lat, base);
        checks++; if (resp_rdata !== 32'hFFFF9234) begin errors++; $display("FAIL half_signed got %h exp ffff9234", resp_rdata); end
        release_resp();
    endtask

    task automatic test_half_store();
        int lat, base, nwr;
        poke(8'h33, 8'h5A);
        do_req(1'b1, 3'b010, 32'h31, 32'hAABBCCDD, lat, base);
        checks++; if (lat !== 3) begin errors++; $display("FAIL hstore_latency got %0d exp 3", lat); end
        checks++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin errors++; $display("FAIL hstore_resp got rdata=%h err=%b exp 0/0", resp_rdata, resp_err); end
        nwr = 0;
        for (int i = base; i < acc_log.size(); i++) if (acc_log[i].we) nwr++;
        checks++; if (nwr !== 2) begin errors++; $display("FAIL hstore_pulses got %0d exp 2", nwr); end
        if (acc_log.size() >= base + 2) begin
            checks++; if (acc_log[base].addr !== 32'h31 || acc_log[base].wdata !== 8'hDD) begin errors++; $display("FAIL hstore_beat0 got %h/%h exp 31/dd", acc_log[base].addr, acc_log[base].wdata); end
            checks++; if (acc_log[base+1].addr !== 32'h32 || acc_log[base+1].wdata !== 8'hCC) begin errors++; $display("FAIL hstore_beat1 got %h/%h exp 32/cc", acc_log[base+1].addr, acc_log[base+1].wdata); end
        end
        release_resp();
        checks++; if (mem_arr[8'h33] !== 8'h5A) begin errors++; $display("FAIL hstore_neighbor got %h exp 5a", mem_arr[8'h33]); end
        do_req(1'b0, 3'b110, 32'h31, 32'h0, lat, base);
        checks++; if (resp_rdata !== 32'h0000CCDD) begin errors++; $display("FAIL hstore_readback got %h exp 0000ccdd", resp_rdata); end
        release_resp();
    endtask

    task automatic test_wrap();
        int lat, base;
        logic [31:0] exp_addr [4];
        exp_addr[0] = 32'hFFFFFFFE; exp_addr[1] = 32'hFFFFFFFF; exp_addr[2] = 32'h0; exp_addr[3] = 32'h1;
        poke(8'hFE, 8'h11); poke(8'hFF, 8'h22); poke(8'h00, 8'h33); poke(8'h01, 8'h44);
        do_req(1'b0, 3'b000, 32'hFFFFFFFE, 32'h0, lat, base);
        checks++; if (resp_rdata !== 32'h44332211) begin errors++; $display("FAIL wrap_rdata got %h exp 44332211", resp_rdata); end
        checks++; if (acc_log.size() - base !== 4) begin errors++; $display("FAIL wrap_beats got %0d exp 4", acc_log.size() - base); end
        if (acc_log.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (acc_log[base+i].addr !== exp_addr[i]) begin
                    errors++;
                    $display("FAIL wrap_addr%0d got %h exp %h", i, acc_log[base+i].addr, exp_addr[i]);
                end
            end
        end
        release_resp();
    endtask

    task automatic test_illegal();
        int lat, base;
        do_req(1'b0, 3'b011, 32'h10, 32'h0, lat, base);
        checks++; if (lat !== 1) begin errors++; $display("FAIL illegal_latency got %0d exp 1", lat); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
                errors++;
                $display("FAIL illegal_hold%0d got valid=%b err=%b rdata=%h exp 1/1/0", c, resp_valid, resp_err, resp_rdata);
            end
        end
        checks++; if (acc_log.size() !== base) begin errors++; $display("FAIL illegal_no_mem got %0d beats exp 0", acc_log.size() - base); end
        release_resp();
        do_req(1'b1, 3'b101, 32'h10, 32'hFFFFFFFF, lat, base);
        checks++; if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin errors++; $display("FAIL illegal_store got err=%b rdata=%h exp 1/0", resp_err, resp_rdata); end
        checks++; if (acc_log.size() !== base) begin errors++; $display("FAIL illegal_store_no_mem got %0d beats exp 0", acc_log.size() - base); end
        release_resp();
    endtask

    task automatic test_reset_abort();
        for (int i = 0; i < 4; i++) poke(8'h50 + 8'(i), 8'h00);
        @(negedge clk);
        req_we = 1'b1; req_op = 3'b000; req_addr = 32'h50; req_wdata = 32'h11223344; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h50 || mem_wdata !== 8'h44) begin errors++; $display("FAIL abort_beat0 got we=%b addr=%h wdata=%h exp 1/50/44", mem_we, mem_addr, mem_wdata); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || mem_we !== 1'b0 || mem_en !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL abort_state got ready=%b we=%b en=%b valid=%b exp 1/0/0/0", req_ready, mem_we, mem_en, resp_valid); end
        rst = 1'b0;
        checks++; if (mem_arr[8'h50] !== 8'h44) begin errors++; $display("FAIL abort_byte0 got %h exp 44", mem_arr[8'h50]); end
        checks++; if (mem_arr[8'h51] !== 8'h00 || mem_arr[8'h52] !== 8'h00 || mem_arr[8'h53] !== 8'h00) begin errors++; $display("FAIL abort_rest got %h %h %h exp 00 00 00", mem_arr[8'h51], mem_arr[8'h52], mem_arr[8'h53]); end
    endtask

    task automatic test_back_to_back();
        int lat, base, base2;
        do_req(1'b0, 3'b101, 32'h20, 32'h0, lat, base);
        base2 = acc_log.size();
        req_we = 1'b0; req_op = 3'b000; req_addr = 32'h10; req_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h80 || req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ignore got valid=%b rdata=%h ready=%b exp 1/80/0", resp_valid, resp_rdata, req_ready); end
        release_resp();
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got ready=%b valid=%b exp 1/0", req_ready, resp_valid); end
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h10) begin errors++; $display("FAIL b2b_accept got en=%b addr=%h exp 1/10", mem_en, mem_addr); end
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 5 || resp_rdata !== 32'h12345678) begin errors++; $display("FAIL b2b_resp got lat=%0d rdata=%h exp 5/12345678", lat, resp_rdata); end
        checks++; if (acc_log.size() - base2 !== 4) begin errors++; $display("FAIL b2b_beats got %0d exp 4", acc_log.size() - base2); end
        release_resp();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        test_reset();
        test_word_load();
        test_byte_ext();
        test_half_store();
        test_wrap();
        test_illegal();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
